// File: rtl/mlp_cmd_pkg.sv
// Shared constants for the MLP host command loader: opcodes, status bytes
// and the loader FSM state encoding.
package mlp_cmd_pkg;

  localparam logic [7:0] OP_LOAD_W = 8'h01;
  localparam logic [7:0] OP_LOAD_A = 8'h02;
  localparam logic [7:0] OP_RUN    = 8'h03;
  localparam logic [7:0] OP_WRESET = 8'h05;

  localparam logic [7:0] STS_OK  = 8'hA5;
  localparam logic [7:0] STS_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_PAYLOAD,
    S_A_COUNT,
    S_A_PAYLOAD,
    S_RUN_WAIT,
    S_TX_STATUS,
    S_TX_RESULT
  } state_e;

  // States in which the loader takes a host byte.
  function automatic logic accepts_bytes(input state_e s);
    return (s == S_IDLE) || (s == S_W_PAYLOAD) || (s == S_A_COUNT) || (s == S_A_PAYLOAD);
  endfunction

endpackage

// File: rtl/mlp_cmd_loader.sv
// Host command front end for the MLP top. Parses the host byte stream, loads
// weights and activations, launches a run and returns the two 32-bit
// accumulators as 8 little-endian bytes. All outputs are registered.
// Optional build macro MLP_TIMEOUT_EN adds a RUN_WAIT watchdog.
module mlp_cmd_loader
  import mlp_cmd_pkg::*;
#(
  parameter int ACT_DEPTH      = 16,
  parameter int W_PER_COL      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_in,
  output logic        wf_reset,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic        layer_complete,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  output logic        err
);

  localparam logic [8:0] W_SPLIT = 9'(W_PER_COL);
  localparam logic [8:0] W_LAST  = 9'(2 * W_PER_COL - 1);
  localparam logic [8:0] ACT_MAX = 9'(ACT_DEPTH);

  if (W_PER_COL < 1 || W_PER_COL > 255) begin : g_bad_wpc
    $error("W_PER_COL out of range");
  end
  if (ACT_DEPTH < 1 || ACT_DEPTH > 255) begin : g_bad_depth
    $error("ACT_DEPTH out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range");
  end

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  tgt_q, tgt_d;
  logic        drop_q, drop_d;
  logic [7:0]  row0_q, row0_d;
  logic [63:0] res_q, res_d;
  logic        lc_prev_q;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        push0_q, push0_d;
  logic        push1_q, push1_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wfr_q, wfr_d;
  logic        av_q, av_d;
  logic [15:0] ad_q, ad_d;
  logic        start_q, start_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
`ifdef MLP_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  logic       take;
  logic       go_sts;
  logic [7:0] sts_byte;

  assign take = rx_valid && rx_ready_q;

  // Next-state and registered-output decode for the command FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    drop_d     = drop_q;
    row0_d     = row0_q;
    res_d      = res_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    push0_d    = 1'b0;
    push1_d    = 1'b0;
    wdata_d    = wdata_q;
    wfr_d      = 1'b0;
    av_d       = 1'b0;
    ad_d       = ad_q;
    start_d    = 1'b0;
    wr_d       = wr_q;
    err_d      = err_q;
    go_sts     = 1'b0;
    sts_byte   = STS_OK;
`ifdef MLP_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (take) begin
          case (rx_data)
            OP_LOAD_W: begin
              state_d = S_W_PAYLOAD;
              cnt_d   = '0;
            end
            OP_LOAD_A: state_d = S_A_COUNT;
            OP_RUN: begin
              if (wr_q) begin
                start_d = 1'b1;
                state_d = S_RUN_WAIT;
`ifdef MLP_TIMEOUT_EN
                tmo_d   = '0;
`endif
              end else begin
                err_d    = 1'b1;
                go_sts   = 1'b1;
                sts_byte = STS_ERR;
              end
            end
            OP_WRESET: begin
              wfr_d  = 1'b1;
              wr_d   = 1'b0;
              go_sts = 1'b1;
            end
            default: begin
              err_d    = 1'b1;
              go_sts   = 1'b1;
              sts_byte = STS_ERR;
            end
          endcase
        end
      end

      S_W_PAYLOAD: begin
        if (take) begin
          wdata_d = rx_data;
          if (cnt_q < W_SPLIT) push0_d = 1'b1;
          else                 push1_d = 1'b1;
          if (cnt_q == W_LAST) begin
            wr_d   = 1'b1;
            go_sts = 1'b1;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      S_A_COUNT: begin
        if (take) begin
          cnt_d  = '0;
          tgt_d  = {rx_data, 1'b0};
          drop_d = ({1'b0, rx_data} > ACT_MAX);
          if (rx_data == 8'd0) begin
            go_sts = 1'b1;
          end else begin
            state_d = S_A_PAYLOAD;
            if ({1'b0, rx_data} > ACT_MAX) err_d = 1'b1;
          end
        end
      end

      S_A_PAYLOAD: begin
        if (take) begin
          if (!cnt_q[0]) begin
            row0_d = rx_data;
          end else if (!drop_q) begin
            av_d = 1'b1;
            ad_d = {rx_data, row0_q};
          end
          if (cnt_q == tgt_q - 9'd1) begin
            go_sts   = 1'b1;
            sts_byte = drop_q ? STS_ERR : STS_OK;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end

      S_RUN_WAIT: begin
        if (layer_complete && !lc_prev_q) begin
          res_d      = {acc1, acc0};
          tx_data_d  = acc0[7:0];
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_TX_RESULT;
        end
`ifdef MLP_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          go_sts   = 1'b1;
          sts_byte = STS_ERR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end

      S_TX_STATUS: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_TX_RESULT: begin
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == 9'd7) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            res_d     = res_q >> 8;
            tx_data_d = res_q[15:8];
            cnt_d     = cnt_q + 9'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go_sts) begin
      state_d    = S_TX_STATUS;
      tx_valid_d = 1'b1;
      tx_data_d  = sts_byte;
    end

    rx_ready_d = accepts_bytes(state_d);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tgt_q      <= '0;
      drop_q     <= 1'b0;
      row0_q     <= '0;
      res_q      <= '0;
      lc_prev_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      push0_q    <= 1'b0;
      push1_q    <= 1'b0;
      wdata_q    <= '0;
      wfr_q      <= 1'b0;
      av_q       <= 1'b0;
      ad_q       <= '0;
      start_q    <= 1'b0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
`ifdef MLP_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      drop_q     <= drop_d;
      row0_q     <= row0_d;
      res_q      <= res_d;
      lc_prev_q  <= layer_complete;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      push0_q    <= push0_d;
      push1_q    <= push1_d;
      wdata_q    <= wdata_d;
      wfr_q      <= wfr_d;
      av_q       <= av_d;
      ad_q       <= ad_d;
      start_q    <= start_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
`ifdef MLP_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign rx_ready       = rx_ready_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign wf_push_col0   = push0_q;
  assign wf_push_col1   = push1_q;
  assign wf_data_in     = wdata_q;
  assign wf_reset       = wfr_q;
  assign init_act_valid = av_q;
  assign init_act_data  = ad_q;
  assign start_mlp      = start_q;
  assign weights_ready  = wr_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mlp_cmd_loader.sv
// Randomized bench for mlp_cmd_loader with an expectation-queue model of the
// command protocol and a behavioural stand-in for the MLP top.
module tb_mlp_cmd_loader;

  localparam int ACT_DEPTH = 16;
  localparam int WPC       = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        wf_push_col0, wf_push_col1, wf_reset;
  logic [7:0]  wf_data_in;
  logic        init_act_valid;
  logic [15:0] init_act_data;
  logic        start_mlp, weights_ready, err;
  logic        layer_complete = 1'b0;
  logic [31:0] acc0 = '0, acc1 = '0;

  mlp_cmd_loader #(.ACT_DEPTH(ACT_DEPTH), .W_PER_COL(WPC), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1),
    .wf_data_in(wf_data_in), .wf_reset(wf_reset),
    .init_act_valid(init_act_valid), .init_act_data(init_act_data),
    .start_mlp(start_mlp), .weights_ready(weights_ready),
    .layer_complete(layer_complete), .acc0(acc0), .acc1(acc1), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected observable traffic
  logic [7:0]  exp_c0[$];
  logic [7:0]  exp_c1[$];
  logic [15:0] exp_act[$];
  logic [7:0]  exp_tx[$];
  int          exp_start = 0;
  int          exp_wfr = 0;
  bit          m_err = 0;
  bit          m_wr = 0;

  // MLP stand-in controls
  int          start_seen = 0;
  logic [31:0] run_a0 = '0, run_a1 = '0;
  int          run_delay = 2;
  bit          run_stuck = 0;
  bit          lc_idle = 0;
  int          hold_req = 0;
  bit          gaps = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every DUT output stream against the expectation queues
  initial begin
    bit         prev_hold;
    logic [7:0] prev_data;
    prev_hold = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 0;
      end else begin
        if (wf_push_col0) begin
          if (exp_c0.size() == 0) chk("unexpected_col0_push", 1, 0);
          else chk("col0_byte", wf_data_in, exp_c0.pop_front());
        end
        if (wf_push_col1) begin
          if (exp_c1.size() == 0) chk("unexpected_col1_push", 1, 0);
          else chk("col1_byte", wf_data_in, exp_c1.pop_front());
        end
        if (init_act_valid) begin
          if (exp_act.size() == 0) chk("unexpected_act_write", 1, 0);
          else chk("act_word", init_act_data, exp_act.pop_front());
        end
        if (start_mlp) begin
          start_seen++;
          if (exp_start == 0) chk("unexpected_start", 1, 0);
          else exp_start--;
        end
        if (wf_reset) begin
          if (exp_wfr == 0) chk("unexpected_wf_reset", 1, 0);
          else exp_wfr--;
        end
        if (prev_hold) begin
          chk("tx_valid_hold", tx_valid, 1);
          chk("tx_data_hold", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) chk("unexpected_tx", {56'h0, tx_data}, 64'hDEAD);
          else chk("tx_byte", tx_data, exp_tx.pop_front());
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  end

  // Host response sink: mostly ready, with requested 5-cycle stalls
  initial begin
    int hold_cnt;
    int hold_done;
    hold_cnt = 0;
    hold_done = 0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt == 0 && hold_req > hold_done && tx_valid) begin
        hold_done++;
        hold_cnt = 5;
      end
      if (hold_cnt > 0) begin
        tx_ready = 1'b0;
        hold_cnt--;
      end else begin
        tx_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // MLP stand-in: answers each start pulse with a layer_complete level
  initial begin
    int consumed;
    consumed = 0;
    forever begin
      @(negedge clk);
      if (start_seen > consumed) begin
        consumed++;
        if (run_stuck) begin
          acc0 = 32'hBAD0BAD0;
          acc1 = 32'hBAD1BAD1;
          layer_complete = 1'b1;
          repeat (3) @(negedge clk);
          layer_complete = 1'b0;
          repeat (2) @(negedge clk);
        end
        repeat (run_delay) @(negedge clk);
        acc0 = run_a0;
        acc1 = run_a1;
        layer_complete = 1'b1;
        repeat (3) @(negedge clk);
        layer_complete = 1'b0;
      end else begin
        layer_complete = lc_idle;
        acc0 = $urandom;
        acc1 = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int bound;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    bound = 0;
    while (!rx_ready && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || tx_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk({nm, "_response_timeout"}, exp_tx.size(), 0);
    repeat (2) @(negedge clk);
    chk({nm, "_col0_left"}, exp_c0.size(), 0);
    chk({nm, "_col1_left"}, exp_c1.size(), 0);
    chk({nm, "_act_left"}, exp_act.size(), 0);
    chk({nm, "_start_left"}, exp_start, 0);
    chk({nm, "_wfr_left"}, exp_wfr, 0);
    chk({nm, "_err"}, err, m_err);
    chk({nm, "_weights_ready"}, weights_ready, m_wr);
    chk({nm, "_idle_ready"}, rx_ready, 1);
  endtask

  task automatic cmd_load_w(input logic [7:0] wb[2*WPC], input bit pin);
    for (int i = 0; i < 2 * WPC; i++) begin
      if (i < WPC) exp_c0.push_back(wb[i]);
      else         exp_c1.push_back(wb[i]);
    end
    m_wr = 1;
    exp_tx.push_back(8'hA5);
    if (pin) begin
      chk("pin_col0", {exp_c0[0], exp_c0[1]}, 16'h1112);
      chk("pin_col1", {exp_c1[0], exp_c1[1]}, 16'h2122);
    end
    send_byte(8'h01);
    for (int i = 0; i < 2 * WPC; i++) send_byte(wb[i]);
    wait_done("load_w");
  endtask

  task automatic cmd_load_a(input int k, input bit seq, input bit pin);
    logic [7:0] pay[$];
    for (int i = 0; i < 2 * k; i++) pay.push_back(seq ? 8'(i + 3) : 8'($urandom));
    if (k == 0) begin
      exp_tx.push_back(8'hA5);
    end else if (k > ACT_DEPTH) begin
      m_err = 1;
      exp_tx.push_back(8'hEE);
    end else begin
      for (int w = 0; w < k; w++) exp_act.push_back({pay[2*w+1], pay[2*w]});
      exp_tx.push_back(8'hA5);
    end
    if (pin) chk("pin_act", {exp_act[0], exp_act[1]}, 32'h0403_0605);
    send_byte(8'h02);
    send_byte(8'(k));
    for (int i = 0; i < 2 * k; i++) send_byte(pay[i]);
    wait_done("load_a");
  endtask

  task automatic cmd_run(input logic [31:0] a0, input logic [31:0] a1,
                         input int dly, input bit stuck, input bit pin);
    if (m_wr) begin
      run_a0 = a0;
      run_a1 = a1;
      run_delay = dly;
      run_stuck = stuck;
      exp_start++;
      for (int i = 0; i < 4; i++) exp_tx.push_back(a0[8*i +: 8]);
      for (int i = 0; i < 4; i++) exp_tx.push_back(a1[8*i +: 8]);
      if (pin) begin
        logic [63:0] pk;
        for (int i = 0; i < 8; i++) pk[8*i +: 8] = exp_tx[i];
        chk("pin_result", pk, 64'hFFFFFFFE_00000017);
      end
    end else begin
      m_err = 1;
      exp_tx.push_back(8'hEE);
    end
    send_byte(8'h03);
    wait_done("run");
    run_stuck = 0;
  endtask

  task automatic cmd_wreset();
    exp_wfr++;
    m_wr = 0;
    exp_tx.push_back(8'hA5);
    send_byte(8'h05);
    wait_done("wreset");
  endtask

  task automatic cmd_bad(input logic [7:0] op);
    m_err = 1;
    exp_tx.push_back(8'hEE);
    send_byte(op);
    wait_done("bad_op");
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'h0, rx_ready, tx_valid, tx_data, wf_push_col0, wf_push_col1, wf_data_in,
            wf_reset, init_act_valid, init_act_data, start_mlp, weights_ready, err};
  endfunction

  initial begin
    #800_000;
    $display("FAIL global_watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wb[2*WPC];
    logic [7:0] op;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outputs(), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_ready", rx_ready, 1);

    wb = '{8'h11, 8'h12, 8'h21, 8'h22};
    cmd_load_w(wb, 1);
    cmd_load_a(2, 1, 1);
    cmd_run(32'h0000_0017, 32'hFFFF_FFFE, 3, 0, 1);

    cmd_wreset();
    cmd_run(32'h1, 32'h2, 2, 0, 0);
    cmd_bad(8'h7F);

    hold_req++;
    cmd_load_a(20, 0, 0);
    cmd_load_a(ACT_DEPTH, 0, 0);
    cmd_load_a(0, 0, 0);
    cmd_load_a(ACT_DEPTH + 1, 0, 0);

    // layer_complete already high when the run starts, then edges while idle
    for (int i = 0; i < 2 * WPC; i++) wb[i] = 8'($urandom);
    cmd_load_w(wb, 0);
    lc_idle = 1;
    repeat (3) @(negedge clk);
    cmd_run($urandom, $urandom, 2, 1, 0);
    lc_idle = 0;
    repeat (3) @(negedge clk);
    lc_idle = 1;
    repeat (3) @(negedge clk);
    lc_idle = 0;
    wait_done("idle_edges");

    gaps = 1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          for (int i = 0; i < 2 * WPC; i++) wb[i] = 8'($urandom);
          cmd_load_w(wb, 0);
        end
        2: cmd_load_a($urandom_range(0, 20), 0, 0);
        3: cmd_run($urandom, $urandom, $urandom_range(1, 8), 0, 0);
        4: cmd_wreset();
        default: begin
          op = 8'($urandom);
          while (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h05) op = 8'($urandom);
          if ($urandom_range(0, 3) == 0) hold_req++;
          cmd_bad(op);
        end
      endcase
    end
    gaps = 0;

    // Abort a LOAD_A with reset after its first word has been written
    for (int i = 0; i < 2 * WPC; i++) wb[i] = 8'($urandom);
    cmd_load_w(wb, 0);
    cmd_bad(8'hC3);
    exp_act.push_back(16'h1110);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h12);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outputs(), 0);
    exp_c0.delete();
    exp_c1.delete();
    exp_act.delete();
    exp_tx.delete();
    exp_start = 0;
    exp_wfr = 0;
    m_err = 0;
    m_wr = 0;
    repeat (2) @(negedge clk);
    chk("held_reset_outputs", all_outputs(), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd_load_a(3, 0, 0);
    cmd_run(32'h5, 32'h6, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
